// File: rtl/register_file.sv
// rtl/register_file.sv - MIPS register file, two combinational read ports, one write port, r0 = 0
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit BYPASS_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Reg_Write_En,
   input  logic [ADDR_WIDTH-1:0] Addr_Write_Reg,
   input  logic [DATA_WIDTH-1:0] Reg_Write_Data,
   input  logic [ADDR_WIDTH-1:0] Addr_Read_Reg1,
   input  logic [ADDR_WIDTH-1:0] Addr_Read_Reg2,
   output logic [DATA_WIDTH-1:0] Read_Data1,
   output logic [DATA_WIDTH-1:0] Read_Data2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  write_live;

   // A write only takes effect when enabled and not aimed at the hardwired zero register
   assign write_live = Reg_Write_En && (Addr_Write_Reg != '0);

   // Storage update: reset clears everything and beats any simultaneous write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_live) begin
         regs[Addr_Write_Reg] <= Reg_Write_Data;
      end
   end

   // Read port 1: reset, then r0, then same-cycle forward, then array
   always_comb begin
      Read_Data1 = regs[Addr_Read_Reg1];
      if (reset) begin
         Read_Data1 = '0;
      end else if (Addr_Read_Reg1 == '0) begin
         Read_Data1 = '0;
      end else if (BYPASS_EN && write_live && (Addr_Write_Reg == Addr_Read_Reg1)) begin
         Read_Data1 = Reg_Write_Data;
      end
   end

   // Read port 2: same priority as port 1, forwarded independently
   always_comb begin
      Read_Data2 = regs[Addr_Read_Reg2];
      if (reset) begin
         Read_Data2 = '0;
      end else if (Addr_Read_Reg2 == '0) begin
         Read_Data2 = '0;
      end else if (BYPASS_EN && write_live && (Addr_Write_Reg == Addr_Read_Reg2)) begin
         Read_Data2 = Reg_Write_Data;
      end
   end

endmodule
